debug_unit: RTL and testbench

DEBUG_UNIT -- requirements
Module: debug_unit

---
 rtl/debug_unit.sv | 243 ++++++++++++++++++++++++
 tb/tb_debug_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
// UART-driven debug controller: loads instruction memory, steps the pipeline, dumps state.
// Optional DEBUG_UNIT_ACK_EN: transmit 0x06 once after an instruction load completes.
module debug_unit #(
   parameter int unsigned NB        = 32,
   parameter int unsigned NB_REGS   = 5,
   parameter int unsigned MEM_WORDS = 16
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [7:0]         i_rx_data,
   input  logic               i_rx_valid,
   output logic [7:0]         o_tx_data,
   output logic               o_tx_start,
   input  logic               i_tx_busy,
   output logic               o_step,
   output logic               o_instruction_write_enable,
   output logic [NB-1:0]      o_instruction_address,
   output logic [NB-1:0]      o_instruction_data,
   output logic [NB_REGS-1:0] o_debug_mips_register_number,
   output logic [NB-1:0]      o_debug_address,
   input  logic [NB-1:0]      i_mips_pc,
   input  logic [NB-1:0]      i_mips_alu_result,
   input  logic [NB-1:0]      i_mips_register_data,
   input  logic [NB-1:0]      i_mips_data_memory
);

   localparam int unsigned DumpWords = 2 + 32 + MEM_WORDS;
   localparam int unsigned DumpW     = $clog2(DumpWords);
   localparam logic [DumpW-1:0] FirstReg = DumpW'(2);
   localparam logic [DumpW-1:0] FirstMem = DumpW'(34);
   localparam logic [DumpW-1:0] LastWord = DumpW'(DumpWords - 1);

   typedef enum logic [3:0] {
      StIdle,
      StLoadCount,
      StLoadBytes,
      StWriteInstr,
      StRunCount,
      StRun,
      StDumpSel,
      StDumpSend
`ifdef DEBUG_UNIT_ACK_EN
      , StAck
`endif
   } state_e;

   state_e           state_q, state_d;
   logic [8:0]       word_count_q, word_count_d;
   logic [8:0]       index_q, index_d;
   logic [8:0]       step_cnt_q, step_cnt_d;
   logic [1:0]       byte_cnt_q, byte_cnt_d;
   logic [NB-1:0]    instr_word_q, instr_word_d;
   logic [NB-1:0]    shift_q, shift_d;
   logic [DumpW-1:0] dump_word_q, dump_word_d;
   logic [7:0]       tx_data_q;
   logic             tx_start_q;

   logic             send_ok;
   logic [7:0]       tx_byte;
   logic [NB-1:0]    sel_value;
   logic [DumpW-1:0] reg_offset;
   logic [DumpW-1:0] mem_offset;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q      <= StIdle;
         word_count_q <= '0;
         index_q      <= '0;
         step_cnt_q   <= '0;
         byte_cnt_q   <= '0;
         instr_word_q <= '0;
         shift_q      <= '0;
         dump_word_q  <= '0;
         tx_data_q    <= '0;
         tx_start_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_count_q <= word_count_d;
         index_q      <= index_d;
         step_cnt_q   <= step_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         instr_word_q <= instr_word_d;
         shift_q      <= shift_d;
         dump_word_q  <= dump_word_d;
         tx_data_q    <= tx_byte;
         tx_start_q   <= send_ok;
      end
   end

   // Byte goes out the same cycle the transmitter is seen idle; tx_data_q then holds it.
   always_comb begin
      send_ok = 1'b0;
      tx_byte = tx_data_q;
      if (!i_tx_busy && !tx_start_q) begin
         if (state_q == StDumpSend) begin
            send_ok = 1'b1;
            tx_byte = shift_q[NB-1 -: 8];
         end
`ifdef DEBUG_UNIT_ACK_EN
         if (state_q == StAck) begin
            send_ok = 1'b1;
            tx_byte = 8'h06;
         end
`endif
      end
   end

   assign o_tx_start                 = send_ok;
   assign o_tx_data                  = tx_byte;
   assign o_step                     = (state_q == StRun);
   assign o_instruction_write_enable = (state_q == StWriteInstr);
   assign o_instruction_address      = NB'({index_q, 2'b00});
   assign o_instruction_data         = instr_word_q;

   assign reg_offset = dump_word_q - FirstReg;
   assign mem_offset = dump_word_q - FirstMem;

   always_comb begin
      o_debug_mips_register_number = '0;
      o_debug_address              = '0;
      if (dump_word_q >= FirstReg && dump_word_q < FirstMem) begin
         o_debug_mips_register_number = NB_REGS'(reg_offset);
      end
      if (dump_word_q >= FirstMem) begin
         o_debug_address = NB'({mem_offset, 2'b00});
      end
   end

   always_comb begin
      if (dump_word_q == '0) begin
         sel_value = i_mips_pc;
      end else if (dump_word_q == DumpW'(1)) begin
         sel_value = i_mips_alu_result;
      end else if (dump_word_q < FirstMem) begin
         sel_value = i_mips_register_data;
      end else begin
         sel_value = i_mips_data_memory;
      end
   end

   always_comb begin
      state_d      = state_q;
      word_count_d = word_count_q;
      index_d      = index_q;
      step_cnt_d   = step_cnt_q;
      byte_cnt_d   = byte_cnt_q;
      instr_word_d = instr_word_q;
      shift_d      = shift_q;
      dump_word_d  = dump_word_q;
      case (state_q)
         StIdle: begin
            if (i_rx_valid) begin
               case (i_rx_data)
                  8'h4C: begin
                     index_d    = '0;
                     byte_cnt_d = '0;
                     state_d    = StLoadCount;
                  end
                  8'h53: begin
                     step_cnt_d = 9'd1;
                     state_d    = StRun;
                  end
                  8'h52: state_d = StRunCount;
                  8'h44: begin
                     dump_word_d = '0;
                     state_d     = StDumpSel;
                  end
                  default: ;
               endcase
            end
         end
         StLoadCount: begin
            if (i_rx_valid) begin
               word_count_d = {i_rx_data == 8'h00, i_rx_data};
               byte_cnt_d   = '0;
               state_d      = StLoadBytes;
            end
         end
         StLoadBytes: begin
            if (i_rx_valid) begin
               instr_word_d = {instr_word_q[NB-9:0], i_rx_data};
               byte_cnt_d   = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  state_d = StWriteInstr;
               end
            end
         end
         StWriteInstr: begin
            index_d = index_q + 9'd1;
            if (index_q + 9'd1 == word_count_q) begin
`ifdef DEBUG_UNIT_ACK_EN
               state_d = StAck;
`else
               state_d = StIdle;
`endif
            end else begin
               state_d = StLoadBytes;
            end
         end
         StRunCount: begin
            if (i_rx_valid) begin
               step_cnt_d = {i_rx_data == 8'h00, i_rx_data};
               state_d    = StRun;
            end
         end
         StRun: begin
            step_cnt_d = step_cnt_q - 9'd1;
            if (step_cnt_q == 9'd1) begin
               dump_word_d = '0;
               state_d     = StDumpSel;
            end
         end
         StDumpSel: begin
            shift_d    = sel_value;
            byte_cnt_d = '0;
            state_d    = StDumpSend;
         end
         StDumpSend: begin
            if (send_ok) begin
               shift_d    = shift_q << 8;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  if (dump_word_q == LastWord) begin
                     state_d = StIdle;
                  end else begin
                     dump_word_d = dump_word_q + DumpW'(1);
                     state_d     = StDumpSel;
                  end
               end
            end
         end
`ifdef DEBUG_UNIT_ACK_EN
         StAck: begin
            if (send_ok) begin
               state_d = StIdle;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_debug_unit.sv
// Scoreboard bench for debug_unit: expected writes, step runs and TX bytes are queued at stimulus
// time and popped as the DUT produces them.
`timescale 1ns/1ps
module tb_debug_unit;

   localparam int unsigned NB        = 32;
   localparam int unsigned NB_REGS   = 5;
   localparam int unsigned MEM_WORDS = 16;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [7:0]         rx_data;
   logic               rx_valid;
   logic [7:0]         tx_data;
   logic               tx_start;
   logic               tx_busy;
   logic               step;
   logic               we;
   logic [NB-1:0]      instr_addr;
   logic [NB-1:0]      instr_data;
   logic [NB_REGS-1:0] dbg_reg;
   logic [NB-1:0]      dbg_addr;
   logic [NB-1:0]      pc_val;
   logic [NB-1:0]      alu_val;
   logic [NB-1:0]      reg_data;
   logic [NB-1:0]      mem_data;

   int checks = 0;
   int failures = 0;
   logic [7:0]  tx_q[$];
   logic [63:0] wr_q[$];
   int          step_q[$];
   int          step_run = 0;
   logic [7:0]  last_tx = '0;
   logic        prev_start = 1'b0;
   logic        hold_busy = 1'b0;
   int          busy_cnt = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] reg_val(input logic [NB_REGS-1:0] n);
      return (n == 5'd31) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(n));
   endfunction

   function automatic logic [31:0] mem_val(input logic [NB-1:0] a);
      return {16'h5A5A, a[15:0]};
   endfunction

   assign reg_data = reg_val(dbg_reg);
   assign mem_data = mem_val(dbg_addr);

   // Transmitter model: busy for three cycles after each start.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_cnt <= 0;
      else if (tx_start) busy_cnt <= 3;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy = (busy_cnt != 0) || hold_busy;

   debug_unit #(.NB(NB), .NB_REGS(NB_REGS), .MEM_WORDS(MEM_WORDS)) dut (
      .i_clk                        (clk),
      .i_reset                      (rst_n),
      .i_rx_data                    (rx_data),
      .i_rx_valid                   (rx_valid),
      .o_tx_data                    (tx_data),
      .o_tx_start                   (tx_start),
      .i_tx_busy                    (tx_busy),
      .o_step                       (step),
      .o_instruction_write_enable   (we),
      .o_instruction_address        (instr_addr),
      .o_instruction_data           (instr_data),
      .o_debug_mips_register_number (dbg_reg),
      .o_debug_address              (dbg_addr),
      .i_mips_pc                    (pc_val),
      .i_mips_alu_result            (alu_val),
      .i_mips_register_data         (reg_data),
      .i_mips_data_memory           (mem_data)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_step"}, 64'(step), 64'h0);
      check({tag, "_tx_start"}, 64'(tx_start), 64'h0);
      check({tag, "_tx_data"}, 64'(tx_data), 64'h0);
      check({tag, "_we"}, 64'(we), 64'h0);
      check({tag, "_instr_addr"}, 64'(instr_addr), 64'h0);
      check({tag, "_instr_data"}, 64'(instr_data), 64'h0);
      check({tag, "_dbg_reg"}, 64'(dbg_reg), 64'h0);
      check({tag, "_dbg_addr"}, 64'(dbg_addr), 64'h0);
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int b = 3; b >= 0; b--) tx_q.push_back(w[8*b +: 8]);
   endtask

   task automatic push_dump();
      push_word(pc_val);
      push_word(alu_val);
      for (int r = 0; r < 32; r++) push_word(reg_val(NB_REGS'(r)));
      for (int m = 0; m < MEM_WORDS; m++) push_word(mem_val(NB'(4 * m)));
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      #1;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("reset_async");
      tx_q.delete();
      wr_q.delete();
      step_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(input int budget);
      int i = 0;
      while ((tx_q.size() != 0 || wr_q.size() != 0 || step_q.size() != 0) && i < budget) begin
         @(posedge clk);
         i++;
      end
      check("drain_pending", 64'(tx_q.size() + wr_q.size() + step_q.size()), 64'h0);
      repeat (8) @(posedge clk);
   endtask

   task automatic wait_tx_below(input int n, input int budget);
      int i = 0;
      while (tx_q.size() > n && i < budget) begin
         @(posedge clk);
         i++;
      end
      check("tx_progress_timeout", 64'(tx_q.size() > n), 64'h0);
   endtask

   // Output monitor, sampled on the falling edge.
   initial begin
      logic [63:0] exp;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            step_run   = 0;
            last_tx    = '0;
            prev_start = 1'b0;
         end else begin
            check("step_we_exclusive", 64'(step & we), 64'h0);
            if (step) begin
               step_run++;
            end else if (step_run != 0) begin
               exp = (step_q.size() != 0) ? 64'(step_q.pop_front()) : 64'h0;
               check("step_run_length", 64'(step_run), exp);
               step_run = 0;
            end
            if (we) begin
               exp = (wr_q.size() != 0) ? wr_q.pop_front() : '1;
               check("wr_addr", 64'(instr_addr), 64'(exp[63:32]));
               check("wr_data", 64'(instr_data), 64'(exp[31:0]));
            end
            if (tx_start) begin
               check("tx_start_while_busy", 64'(tx_busy), 64'h0);
               check("tx_start_back_to_back", 64'(prev_start), 64'h0);
               exp = (tx_q.size() != 0) ? 64'(tx_q.pop_front()) : '1;
               check("tx_byte", 64'(tx_data), exp);
               last_tx = tx_data;
            end else if (tx_busy) begin
               check("tx_hold", 64'(tx_data), 64'(last_tx));
            end
            prev_start = tx_start;
         end
      end
   end

   initial begin
      rx_data  = '0;
      rx_valid = 1'b0;
      pc_val   = 32'h0000_0004;
      alu_val  = 32'h1234_5678;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst_n = 1'b1;

      // Two-word load.
      wr_q.push_back({32'h0, 32'h2001_0005});
      wr_q.push_back({32'h4, 32'h0000_0000});
`ifdef DEBUG_UNIT_ACK_EN
      tx_q.push_back(8'h06);
`endif
      send_byte(8'h4C);
      send_byte(8'h02);
      send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      wait_drain(400);

      // Single step then full dump.
      step_q.push_back(1);
      push_dump();
      send_byte(8'h53);
      wait_drain(4000);

      // Unknown command produces nothing.
      send_byte(8'h7A);
      repeat (30) @(posedge clk);

      // 256-step run with a dropped byte mid-run and back-pressure mid-dump.
      pc_val = 32'h0000_0104;
      step_q.push_back(256);
      push_dump();
      send_byte(8'h52);
      send_byte(8'h00);
      repeat (20) @(posedge clk);
      send_byte(8'h4C);
      wait_tx_below(150, 4000);
      #1;
      hold_busy = 1'b1;
      send_byte(8'h53);
      repeat (48) @(posedge clk);
      #1;
      hold_busy = 1'b0;
      wait_drain(4000);

      // Reset mid-dump: nothing resumes afterwards.
      push_dump();
      send_byte(8'h44);
      wait_tx_below(190, 2000);
      pulse_reset();
      repeat (60) @(posedge clk);

      // Reset mid-load, then a fresh single-word load.
      send_byte(8'h4C);
      send_byte(8'h01);
      send_byte(8'hAA);
      send_byte(8'hBB);
      pulse_reset();
      wr_q.push_back({32'h0, 32'h1122_3344});
`ifdef DEBUG_UNIT_ACK_EN
      tx_q.push_back(8'h06);
`endif
      send_byte(8'h4C);
      send_byte(8'h01);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      wait_drain(400);

      repeat (20) @(posedge clk);
      check("final_tx_queue", 64'(tx_q.size()), 64'h0);
      check("final_wr_queue", 64'(wr_q.size()), 64'h0);
      check("final_step_queue", 64'(step_q.size()), 64'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
